// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main control FSM: memory ready handshake, timeout/illegal traps, retire counter.
// Define MC_CONTROL_BNE_EN to decode bne (000101) as a branch taken on Zero==0.
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP_Code,
  input  logic             Mem_Ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             Branch_Ne,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Illegal,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR,
    EXEC, RWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // Last wait-counter value tolerated without Mem_Ready; the next miss traps.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        is_lw;
`ifdef MC_CONTROL_BNE_EN
  logic        is_bne;
`endif

  // State sequencing, memory wait/timeout tracking, sticky traps and retire count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      wait_cnt    <= 16'd0;
      is_lw       <= 1'b0;
      Illegal     <= 1'b0;
      Mem_Err     <= 1'b0;
      Instr_Count <= '0;
`ifdef MC_CONTROL_BNE_EN
      is_bne      <= 1'b0;
`endif
    end else begin
      wait_cnt <= 16'd0;
      case (state)
        FETCH: begin
          if (Mem_Ready) begin
            state <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= TRAP;
            Mem_Err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DECODE: begin
          is_lw <= (OP_Code == OP_LW);
`ifdef MC_CONTROL_BNE_EN
          is_bne <= (OP_Code == OP_BNE);
`endif
          case (OP_Code)
            OP_RTYPE:     state <= EXEC;
            OP_LW, OP_SW: state <= MEMADDR;
            OP_ADDI:      state <= ADDIEX;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
`ifdef MC_CONTROL_BNE_EN
            OP_BNE:       state <= BRANCH;
`endif
            default: begin
              state   <= TRAP;
              Illegal <= 1'b1;
            end
          endcase
        end
        MEMADDR: state <= is_lw ? MEMRD : MEMWR;
        MEMRD: begin
          if (Mem_Ready) begin
            state <= MEMWB;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= TRAP;
            Mem_Err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        MEMWR: begin
          if (Mem_Ready) begin
            state       <= FETCH;
            Instr_Count <= Instr_Count + CNT_W'(1);
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= TRAP;
            Mem_Err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        EXEC:   state <= RWB;
        ADDIEX: state <= ADDIWB;
        MEMWB, RWB, ADDIWB, BRANCH, JUMP: begin
          state       <= FETCH;
          Instr_Count <= Instr_Count + CNT_W'(1);
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Control decode from state; FETCH strobes follow Mem_Ready, everything quiet in reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch_Ne   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (rst) begin
      MemRead = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = Mem_Ready;
          PCWrite = Mem_Ready;
        end
        DECODE:  ALUSrcB = 2'b11;
        MEMADDR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ADDIWB:  RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
`ifdef MC_CONTROL_BNE_EN
          Branch_Ne   = is_bne;
`endif
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: PCWrite = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed scenarios then random instruction streams,
// checked cycle by cycle against an instruction-level model of the expected control sequence.
module tb_multi_cycle_control;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] OP_Code = 6'd0;
  logic Mem_Ready = 1'b0;
  logic PCWrite, PCWriteCond, Branch_Ne, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic Illegal, Mem_Err;
  logic [CW-1:0] Instr_Count;

  multi_cycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .OP_Code(OP_Code), .Mem_Ready(Mem_Ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch_Ne(Branch_Ne),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Illegal(Illegal), .Mem_Err(Mem_Err), .Instr_Count(Instr_Count)
  );

  always #5 clk = ~clk;

  typedef logic [16:0] ctl_t;
  ctl_t act;
  assign act = {PCWrite, PCWriteCond, Branch_Ne, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int n_checks = 0;
  int n_fail = 0;
  int model_count = 0;
  logic model_ill = 1'b0;
  logic model_merr = 1'b0;

  // Control word built from named fields, in the same order as act.
  function automatic ctl_t ctl(input logic pcw, pcc, bne, iord, mrd, mwr, irw, m2r, rdst, rw,
                               srca, input logic [1:0] srcb, aluop, pcsrc);
    return {pcw, pcc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, advance.
  task automatic cyc(input string tag, input ctl_t exp, input logic rdy, input logic [5:0] op);
    Mem_Ready = rdy;
    OP_Code = op;
    #2;
    chk(tag, 32'(act), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Mem_Ready = 1'b1;
    #2;
    chk("rst_ctl_zero", 32'(act), 32'd0);
    chk("rst_count", 32'(Instr_Count), 32'd0);
    chk("rst_illegal", 32'(Illegal), 32'd0);
    chk("rst_mem_err", 32'(Mem_Err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_count = 0;
    model_ill = 1'b0;
    model_merr = 1'b0;
  endtask

  // Memory phase: forced < 0 means random ready, else ready after 'forced' misses.
  task automatic mem_wait(input string tag, input logic is_fetch, input ctl_t base,
                          input int forced, output logic trapped);
    int waits = 0;
    logic rdy;
    ctl_t exp;
    trapped = 1'b0;
    while (1) begin
      if (forced >= 0) rdy = (waits >= forced);
      else rdy = ($urandom_range(0, 3) != 0);
      exp = base;
      if (is_fetch) begin
        exp[16] = rdy;
        exp[10] = rdy;
      end
      cyc(tag, exp, rdy, rnd_op());
      if (rdy) break;
      waits++;
      if (waits == TO) begin
        trapped = 1'b1;
        break;
      end
    end
  endtask

  task automatic after_trap(input int quiet);
    chk("trap_illegal", 32'(Illegal), 32'(model_ill));
    chk("trap_mem_err", 32'(Mem_Err), 32'(model_merr));
    repeat (quiet) cyc("trap_quiet", 17'd0, 1'($urandom), rnd_op());
    chk("trap_count_frozen", 32'(Instr_Count), 32'(model_count));
    do_reset();
  endtask

  task automatic retire();
    model_count = (model_count + 1) % (1 << CW);
    chk("instr_count", 32'(Instr_Count), 32'(model_count));
    chk("no_flags", {30'd0, Illegal, Mem_Err}, 32'd0);
  endtask

  // Whole instruction from FETCH to retirement (or trap) with the expected control per cycle.
  task automatic run_instr(input logic [5:0] op, input int fw_fetch, input int fw_mem);
    logic tr;
    mem_wait("fetch", 1'b1, ctl(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00), fw_fetch, tr);
    if (tr) begin
      model_merr = 1'b1;
      after_trap(3);
      return;
    end
    cyc("decode", ctl(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), 1'($urandom), op);
    case (op)
      6'b000000: begin
        cyc("exec", ctl(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00), 1'($urandom), rnd_op());
        cyc("rwb", ctl(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00), 1'($urandom), rnd_op());
        retire();
      end
      6'b100011, 6'b101011: begin
        cyc("memaddr", ctl(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 1'($urandom), rnd_op());
        if (op == 6'b100011) mem_wait("memrd", 1'b0, ctl(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00), fw_mem, tr);
        else mem_wait("memwr", 1'b0, ctl(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), fw_mem, tr);
        if (tr) begin
          model_merr = 1'b1;
          after_trap(3);
        end else begin
          if (op == 6'b100011)
            cyc("memwb", ctl(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00), 1'($urandom), rnd_op());
          retire();
        end
      end
      6'b001000: begin
        cyc("addiex", ctl(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 1'($urandom), rnd_op());
        cyc("addiwb", ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00), 1'($urandom), rnd_op());
        retire();
      end
      6'b000100: begin
        cyc("beq", ctl(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), 1'($urandom), rnd_op());
        retire();
      end
`ifdef MC_CONTROL_BNE_EN
      6'b000101: begin
        cyc("bne", ctl(0,1,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), 1'($urandom), rnd_op());
        retire();
      end
`endif
      6'b000010: begin
        cyc("jump", ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10), 1'($urandom), rnd_op());
        retire();
      end
      default: begin
        model_ill = 1'b1;
        after_trap(10);
      end
    endcase
  endtask

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};

  initial begin
    #1;
    do_reset();
    // Directed scenarios.
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001000, 2, 0);
    run_instr(6'b101011, 1, 3);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, 1000, 0);
    run_instr(6'b100011, 0, 1000);
    run_instr(6'b000101, 0, 0);
    // Reset in the middle of an R-type: nothing retires, fetch restarts cleanly.
    cyc("mid_fetch", ctl(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00), 1'b1, rnd_op());
    cyc("mid_decode", ctl(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), 1'b0, 6'b000000);
    cyc("mid_exec", ctl(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00), 1'b0, rnd_op());
    do_reset();
    run_instr(6'b000000, 0, 0);
    // Legal stream with bounded waits: wraps the retire counter several times.
    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    // Fully random stream including illegal opcodes and unbounded ready patterns.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) run_instr(rnd_op(), -1, -1);
      else run_instr(legal_ops[$urandom_range(0, 5)], -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
